paridade_tx: RTL and testbench
==============================

# paridade_tx

Parity-generating word transmitter, the sending end of the 5-bit + parity link that the 7-segment display decoder consumes. It accepts a 5-bit value over a valid/ready handshake, rejects values outside the displayable range, and computes the parity bit. It presents the protected word (b1..b5, b_par) as registered parallel outputs and also shifts it out as a framed serial stream on `tx`.

## Interface
- `ODD_PARITY`, 0: 0 = even parity (total ones across b1..b5, b_par is even); 1 = odd parity.
- `BIT_CYCLES`, 1: clock cycles per serial bit, ≥1.
- `MAX_VALUE`, 19: largest accepted input value; larger values are rejected.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  5  value to send; din[4] = b1 (MSB), din[0] = b5.
- `din_valid`  in  1  `din` is offered.
- `din_ready`  out  1  block can accept; registered.
- `b1`,`b2`,`b3`,`b4`,`b5`  out  1 each  registered parallel data bits, b1 = MSB.
- `b_par`  out  1  registered parity bit for the current parallel word.
- `word_valid`  out  1  one-cycle pulse when the parallel word updates.
- `err_range`  out  1  one-cycle pulse when a value > MAX_VALUE is rejected.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  frame in progress.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE:** `din_ready`=1. A transfer occurs on a rising edge with `din_valid`&`din_ready`.
  - **din ≤ MAX_VALUE:**
    - Latch `din` into b1..b5.
    - b_par = ^din ^ ODD_PARITY.
    - Pulse `word_valid`.
    - Load the 6-bit shift register {b1,b2,b3,b4,b5,b_par}.
    - Go to START with `busy`=1 and `din_ready`=0.
  - **din > MAX_VALUE:**
    - Pulse `err_range`.
    - Leave parallel outputs unchanged.
    - No frame is sent; stay in IDLE with `din_ready`=1.
- **START:** `tx`=0 for BIT_CYCLES cycles, then go to DATA.
- **DATA:** send 6 bits MSB first (b1, b2, b3, b4, b5, b_par), each for BIT_CYCLES cycles. Bit counter 0..5; after bit 5, go to STOP.
- **STOP:** `tx`=1 for BIT_CYCLES cycles, then go to IDLE. `busy`=0 and `din_ready`=1 from that edge on.
- **Input while busy:** `din_valid` is ignored (`din_ready`=0). The source must hold the value.
- **Parallel outputs:** hold their value through the frame and afterwards, until the next accepted word.
- **Counter rules:** bit-cycle counter width = max(1, clog2(BIT_CYCLES)); it wraps to 0 at BIT_CYCLES-1. The bit index wraps only via the state change.
- **Reset (any time, including mid-frame):** the frame is aborted immediately, with no partial stop bit. Reset values:
  - state = IDLE
  - `tx`=1
  - b1..b5 = 0
  - b_par = ODD_PARITY (a parity-consistent all-zero word)
  - `word_valid`=0, `err_range`=0, `busy`=0, `din_ready`=0

## Timing
- **Ready after reset:** `din_ready` goes 1 on the first rising edge after `rst` deasserts.
- **Accept edge k:**
  - b1..b5, b_par and `word_valid` update at edge k. `word_valid` is high for cycle k..k+1 only.
  - `tx` falls (start bit) at edge k.
  - Start bit occupies cycles [k, k+BIT_CYCLES).
  - Data bit i occupies [k+(1+i)·BIT_CYCLES, k+(2+i)·BIT_CYCLES).
  - Stop bit ends at k+8·BIT_CYCLES. `din_ready` returns to 1 at that edge.
- **Throughput:** one word per 8·BIT_CYCLES cycles. Back-to-back is allowed: a word can be accepted on the same edge `din_ready` rises.
- **Rejection:** `err_range` at edge k, high for one cycle. The next value can be accepted at edge k+1.
- **Outputs:** all are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset mid-frame:** assert `rst` during DATA with BIT_CYCLES=1 -> `tx`=1, `busy`=0, b1..b5=0, b_par=0 immediately. `din_ready`=1 one edge after release.
- **Even parity, din=5'b10011 (19), BIT_CYCLES=1:**
  - b1..b5 = 1,0,0,1,1; b_par = 1; `word_valid` pulse.
  - `tx` over 8 cycles = 0,1,0,0,1,1,1,1.
  - `din_ready` low for exactly 8 cycles.
- **Odd parity (ODD_PARITY=1), din=5'b00000:** b_par = 1. Serial frame = 0,0,0,0,0,0,1,1.
- **Range check, din=20 and then din=31:** each gives a one-cycle `err_range` pulse. Parallel outputs unchanged, `tx` stays 1, `busy` stays 0.
- **BIT_CYCLES=3, din=7 held valid continuously:**
  - Each bit lasts 3 cycles; frames repeat every 24 cycles with no idle gap.
  - b_par = 1 (even parity).
- **Handshake under load:** `din_valid` toggled randomly mid-frame with changing `din` -> no acceptance while `busy`. The parallel word and `tx` match only the accepted values, and every received frame passes the display decoder's parity check.

Source files
------------

// File: rtl/paridade_tx.sv
// Parity-protected 5-bit word transmitter: presents the word and its parity bit
// as registered parallel outputs and shifts them out as a start/6-bit/stop frame.
module paridade_tx #(
  parameter bit          ODD_PARITY = 1'b0,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned MAX_VALUE  = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       b4,
  output logic       b5,
  output logic       b_par,
  output logic       word_valid,
  output logic       err_range,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned   CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_idx;
  logic [5:0]    shreg;
  logic          bit_end;
  logic          in_range;
  logic          din_par;
  logic          offer;

  always_comb begin
    bit_end  = (cyc_cnt == CNT_LAST);
    in_range = (32'(din) <= MAX_VALUE);
    din_par  = (^din) ^ ODD_PARITY;
    // The last stop-bit cycle also takes a word so frames can run back-to-back
    // without an idle cycle between them.
    offer    = din_valid && (((state == S_IDLE) && din_ready) ||
                             ((state == S_STOP) && bit_end));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      b1         <= 1'b0;
      b2         <= 1'b0;
      b3         <= 1'b0;
      b4         <= 1'b0;
      b5         <= 1'b0;
      b_par      <= ODD_PARITY;
      word_valid <= 1'b0;
      err_range  <= 1'b0;
      busy       <= 1'b0;
      din_ready  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      err_range  <= 1'b0;
      if (offer && in_range) begin
        {b1, b2, b3, b4, b5} <= din;
        b_par      <= din_par;
        word_valid <= 1'b1;
        shreg      <= {din, din_par};
        state      <= S_START;
        cyc_cnt    <= '0;
        bit_idx    <= '0;
        tx         <= 1'b0;
        busy       <= 1'b1;
        din_ready  <= 1'b0;
      end else begin
        if (offer) err_range <= 1'b1;
        if (state != S_IDLE) cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
        case (state)
          S_IDLE: din_ready <= 1'b1;
          S_START: begin
            if (bit_end) begin
              state   <= S_DATA;
              bit_idx <= '0;
              tx      <= shreg[5];
            end
          end
          S_DATA: begin
            if (bit_end) begin
              if (bit_idx == 3'd5) begin
                state <= S_STOP;
                tx    <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx      <= shreg[4];
                shreg   <= {shreg[4:0], 1'b0};
              end
            end
          end
          default: begin
            if (bit_end) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              din_ready <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_paridade_tx.sv
// Directed bench for paridade_tx: even/odd parity at BIT_CYCLES=1, BIT_CYCLES=3
// back-to-back frames, range rejection, mid-frame reset and a randomized handshake.
module tb_paridade_tx;

  logic clk, rst;
  logic [4:0] d0, d1, d2;
  logic v0, v1, v2;
  wire [4:0] bw0, bw1, bw2;
  wire bp0, bp1, bp2, wv0, wv1, wv2, er0, er1, er2;
  wire tx0, tx1, tx2, bz0, bz1, bz2, rd0, rd1, rd2;

  int total = 0;
  int bad   = 0;

  paridade_tx #(.ODD_PARITY(1'b0), .BIT_CYCLES(1), .MAX_VALUE(19)) dut0 (
    .clk(clk), .rst(rst), .din(d0), .din_valid(v0), .din_ready(rd0),
    .b1(bw0[4]), .b2(bw0[3]), .b3(bw0[2]), .b4(bw0[1]), .b5(bw0[0]),
    .b_par(bp0), .word_valid(wv0), .err_range(er0), .tx(tx0), .busy(bz0));

  paridade_tx #(.ODD_PARITY(1'b1), .BIT_CYCLES(1), .MAX_VALUE(19)) dut1 (
    .clk(clk), .rst(rst), .din(d1), .din_valid(v1), .din_ready(rd1),
    .b1(bw1[4]), .b2(bw1[3]), .b3(bw1[2]), .b4(bw1[1]), .b5(bw1[0]),
    .b_par(bp1), .word_valid(wv1), .err_range(er1), .tx(tx1), .busy(bz1));

  paridade_tx #(.ODD_PARITY(1'b0), .BIT_CYCLES(3), .MAX_VALUE(19)) dut2 (
    .clk(clk), .rst(rst), .din(d2), .din_valid(v2), .din_ready(rd2),
    .b1(bw2[4]), .b2(bw2[3]), .b3(bw2[2]), .b4(bw2[1]), .b5(bw2[0]),
    .b_par(bp2), .word_valid(wv2), .err_range(er2), .tx(tx2), .busy(bz2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] f0, f1, f2, m_frame;
  logic [4:0] m_word;
  logic       m_par, m_ready, acc, rej, exp_tx;
  int         m_left;

  initial begin
    f0 = 8'b0100_1111;   // start, 10011, parity 1, stop
    f1 = 8'b0000_0011;   // start, 00000, odd parity 1, stop
    f2 = 8'b0001_1111;   // start, 00111, parity 1, stop
    rst = 1'b1;
    {v0, v1, v2} = '0;
    {d0, d1, d2} = '0;
    repeat (2) tick();

    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", bz0, 1'b0);
    chk("rst_ready", rd0, 1'b0);
    chk("rst_word", bw0, 5'd0);
    chk("rst_par_even", bp0, 1'b0);
    chk("rst_par_odd", bp1, 1'b1);
    chk("rst_wv", wv0, 1'b0);
    chk("rst_err", er0, 1'b0);

    @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_held_low", rd0, 1'b0);
    tick();
    chk("ready_up0", rd0, 1'b1);
    chk("ready_up1", rd1, 1'b1);
    chk("ready_up2", rd2, 1'b1);

    // 19 on the even-parity link and 0 on the odd-parity link, side by side
    d0 = 5'd19; v0 = 1'b1;
    d1 = 5'd0;  v1 = 1'b1;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    chk("even_word", bw0, 5'b10011);
    chk("even_par", bp0, 1'b1);
    chk("odd_word", bw1, 5'b00000);
    chk("odd_par", bp1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("even_tx", tx0, f0[7-i]);
      chk("odd_tx", tx1, f1[7-i]);
      chk("even_wv", wv0, (i == 0));
      chk("even_ready", rd0, 1'b0);
      chk("even_busy", bz0, 1'b1);
      tick();
    end
    chk("even_ready_back", rd0, 1'b1);
    chk("even_busy_done", bz0, 1'b0);
    chk("even_tx_idle", tx0, 1'b1);
    chk("odd_ready_back", rd1, 1'b1);
    chk("even_word_hold", bw0, 5'b10011);
    chk("even_par_hold", bp0, 1'b1);

    // out-of-range values 20 and 31
    d0 = 5'd20; v0 = 1'b1;
    tick();
    chk("rej20_err", er0, 1'b1);
    chk("rej20_word", bw0, 5'b10011);
    chk("rej20_par", bp0, 1'b1);
    chk("rej20_tx", tx0, 1'b1);
    chk("rej20_busy", bz0, 1'b0);
    chk("rej20_ready", rd0, 1'b1);
    chk("rej20_wv", wv0, 1'b0);
    d0 = 5'd31;
    tick();
    chk("rej31_err", er0, 1'b1);
    chk("rej31_word", bw0, 5'b10011);
    chk("rej31_tx", tx0, 1'b1);
    chk("rej31_busy", bz0, 1'b0);
    v0 = 1'b0;
    tick();
    chk("rej_err_clear", er0, 1'b0);

    // reset during DATA while tx is low
    d0 = 5'd5; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    chk("w5_word", bw0, 5'b00101);
    chk("w5_par", bp0, 1'b0);
    repeat (2) tick();
    chk("w5_tx_b2", tx0, 1'b0);
    chk("w5_busy", bz0, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx0, 1'b1);
    chk("midrst_busy", bz0, 1'b0);
    chk("midrst_word", bw0, 5'd0);
    chk("midrst_par", bp0, 1'b0);
    chk("midrst_ready", rd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("midrst_ready_up", rd0, 1'b1);
    chk("midrst_tx_idle", tx0, 1'b1);

    // BIT_CYCLES=3, 7 held valid: two frames with no gap
    d2 = 5'd7; v2 = 1'b1;
    tick();
    chk("bc3_word", bw2, 5'b00111);
    chk("bc3_par", bp2, 1'b1);
    for (int i = 0; i < 48; i++) begin
      chk("bc3_tx", tx2, f2[7-((i/3)%8)]);
      chk("bc3_wv", wv2, ((i % 24) == 0));
      chk("bc3_busy", bz2, 1'b1);
      chk("bc3_ready", rd2, 1'b0);
      if (i == 47) v2 = 1'b0;
      tick();
    end
    chk("bc3_idle_ready", rd2, 1'b1);
    chk("bc3_idle_busy", bz2, 1'b0);
    chk("bc3_idle_tx", tx2, 1'b1);

    // random valid/din on the even link against a cycle model
    m_ready = 1'b1; m_left = 0; m_word = 5'd0; m_par = 1'b0; m_frame = 8'hFF;
    for (int n = 0; n < 120; n++) begin
      v0 = 1'($urandom_range(0, 1));
      d0 = 5'($urandom_range(0, 31));
      acc = 1'b0; rej = 1'b0;
      if (v0 && ((m_left == 0) ? m_ready : (m_left == 1))) begin
        if (d0 <= 5'd19) acc = 1'b1;
        else rej = 1'b1;
      end
      if (acc) begin
        m_word  = d0;
        m_par   = ^d0;
        m_frame = {1'b0, d0, ^d0, 1'b1};
        m_left  = 8;
        m_ready = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_ready = 1'b1;
      end else begin
        m_ready = 1'b1;
      end
      tick();
      exp_tx = (m_left > 0) ? m_frame[m_left-1] : 1'b1;
      chk("load_tx", tx0, exp_tx);
      chk("load_busy", bz0, (m_left > 0));
      chk("load_ready", rd0, m_ready);
      chk("load_word", bw0, m_word);
      chk("load_par", bp0, m_par);
      chk("load_wv", wv0, acc);
      chk("load_err", er0, rej);
      chk("load_parity_ok", ^{bw0, bp0}, 1'b0);
    end
    v0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
